// File: rtl/apb_master.sv
// APB master: one command in, one response pulse out; response 3 cycles after accept plus slave wait states.
// Backpressure: cmd_ready_o is low from SETUP until the IDLE cycle that carries the response.
module apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       m_apb_pclk_i,
    input  logic       m_apb_preset_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [7:0] cmd_addr_i,
    input  logic       cmd_write_i,
    input  logic [7:0] cmd_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_err_o,
    output logic       m_apb_psel_o,
    output logic       m_apb_penable_o,
    output logic [7:0] m_apb_paddr_o,
    output logic       m_apb_pwrite_o,
    output logic [7:0] m_apb_pwdata_o,
    input  logic [7:0] m_apb_prdata_i,
    input  logic       m_apb_pready_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Counter value seen in the last ACCESS cycle allowed before abort.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tmo_cnt;
    logic       tmo_hit;
    logic       done;
    logic       abort;

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        abort     = 1'b0;
        tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
        case (state)
            IDLE:   if (cmd_valid_i) state_nxt = SETUP;
            SETUP:  state_nxt = ACCESS;
            ACCESS: begin
                // A ready slave wins over a simultaneous timeout.
                if (m_apb_pready_i) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge m_apb_pclk_i) begin
        if (m_apb_preset_i) state <= IDLE;
        else                state <= state_nxt;
    end

    always_ff @(posedge m_apb_pclk_i) begin
        if (m_apb_preset_i) begin
            m_apb_paddr_o  <= 8'h00;
            m_apb_pwrite_o <= 1'b0;
            m_apb_pwdata_o <= 8'h00;
            rsp_valid_o    <= 1'b0;
            rsp_err_o      <= 1'b0;
            rsp_rdata_o    <= 8'h00;
            tmo_cnt        <= 8'h00;
        end else begin
            rsp_valid_o <= done || abort;
            rsp_err_o   <= abort;
            if (done || abort)
                rsp_rdata_o <= (done && !m_apb_pwrite_o) ? m_apb_prdata_i : 8'h00;
            if (state == IDLE && cmd_valid_i) begin
                m_apb_paddr_o  <= cmd_addr_i;
                m_apb_pwrite_o <= cmd_write_i;
                m_apb_pwdata_o <= cmd_wdata_i;
            end
            if (state == SETUP)
                tmo_cnt <= 8'h00;
            else if (state == ACCESS && !m_apb_pready_i)
                tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    assign cmd_ready_o     = (state == IDLE);
    assign m_apb_psel_o    = (state != IDLE);
    assign m_apb_penable_o = (state == ACCESS);

endmodule
